restoring_divider: RTL and testbench



---
 rtl/divider_pkg.sv | 18 +
 rtl/Subtractor_Nbit.sv | 34 +++
 rtl/adder4_slice.sv | 23 ++
 rtl/restoring_divider.sv | 126 ++++++++++++
 tb/tb_restoring_divider.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared constants for the restoring divider: FSM encoding, default width and
// the iteration-counter sizing helper.
package divider_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/Subtractor_Nbit.sv
// WIDTH+1-bit subtractor a - b built from chained 4-bit adder slices plus one
// extra top bit; carry_out=1 means no borrow (a >= b).
module Subtractor_Nbit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           carry_out
);

  localparam int SLICES = WIDTH / 4;

  logic [WIDTH:0]  b_inv;
  logic [SLICES:0] carry;

  assign b_inv    = ~b;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < SLICES; i++) begin : g_slice
    adder4_slice u_slice (
      .a    (a[4*i +: 4]),
      .b    (b_inv[4*i +: 4]),
      .cin  (carry[i]),
      .sum  (diff[4*i +: 4]),
      .cout (carry[i + 1])
    );
  end

  assign diff[WIDTH] = a[WIDTH] ^ b_inv[WIDTH] ^ carry[SLICES];
  assign carry_out   = (a[WIDTH] & b_inv[WIDTH]) |
                       (carry[SLICES] & (a[WIDTH] ^ b_inv[WIDTH]));

endmodule

// File: rtl/adder4_slice.sv
// 4-bit ripple-carry adder slice shared with the reducer datapath.
module adder4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  always_comb begin
    carry[0] = cin;
    sum      = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[4];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock behind start/done.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; done pulse from previous op clears here
//   ST_RUN  | one shift/trial-subtract per edge, counter counts down
//   ST_DONE | load quotient/remainder (sign fixup), pulse done
module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] dvd_sr;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0] partial_rem;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           no_borrow;
  logic           dz;
`ifdef DIVIDER_SIGNED_EN
  logic [WIDTH-1:0] dvd_orig;
  logic             neg_q;
  logic             neg_r;
`endif

  // Dividend register doubles as the quotient shift register.
  assign shifted = (partial_rem << 1) | {{WIDTH{1'b0}}, dvd_sr[WIDTH-1]};

  Subtractor_Nbit #(.WIDTH(WIDTH)) u_sub (
    .a         (shifted),
    .b         ({1'b0, dvs}),
    .diff      (trial),
    .carry_out (no_borrow)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      dvd_sr      <= '0;
      dvs         <= '0;
      partial_rem <= '0;
      dz          <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      dvd_orig    <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            partial_rem <= '0;
            cnt         <= CW'(WIDTH);
            dz          <= (divisor == '0);
`ifdef DIVIDER_SIGNED_EN
            dvd_sr      <= dividend[WIDTH-1] ? -dividend : dividend;
            dvs         <= divisor[WIDTH-1]  ? -divisor  : divisor;
            dvd_orig    <= dividend;
            neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r       <= dividend[WIDTH-1];
`else
            dvd_sr      <= dividend;
            dvs         <= divisor;
`endif
            state       <= (divisor == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          partial_rem <= no_borrow ? trial : shifted;
          dvd_sr      <= {dvd_sr[WIDTH-2:0], no_borrow};
          cnt         <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          done        <= 1'b1;
          div_by_zero <= dz;
          state       <= ST_IDLE;
`ifdef DIVIDER_SIGNED_EN
          if (dz) begin
            quotient  <= '1;
            remainder <= dvd_orig;
          end else begin
            quotient  <= neg_q ? -dvd_sr : dvd_sr;
            remainder <= neg_r ? -partial_rem[WIDTH-1:0] : partial_rem[WIDTH-1:0];
          end
`else
          if (dz) begin
            quotient  <= '1;
            remainder <= dvd_sr;
          end else begin
            quotient  <= dvd_sr;
            remainder <= partial_rem[WIDTH-1:0];
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: timeline/arithmetic reference model
// compared every cycle, plus directed literal cases and randomized traffic.
module tb_restoring_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int model_dones = 0;

  always #5 clk = ~clk;

  restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the divide rules.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    int sa, sb;
    sa = 0;
    sb = 0;
    if (b == '0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else begin
      dz = 1'b0;
`ifdef DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
`else
      q  = a / b;
      r  = a % b;
`endif
    end
  endtask

  // Timeline model: an accepted op stays busy for its latency, then results land.
  int           m_left = 0;
  logic         m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_q    = '0;
      m_r    = '0;
      m_dz   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_q    = p_q;
          m_r    = p_r;
          m_dz   = p_dz;
          model_dones++;
        end
      end else if (start) begin
        ref_div(dividend, divisor, p_q, p_r, p_dz);
        m_left = (divisor == '0) ? 1 : W + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, (m_left != 0));
      chk("done", done, m_done);
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
      chk("div_by_zero", div_by_zero, m_dz);
    end
  end

  task automatic wait_idle();
    @(posedge clk); #1;
    for (int i = 0; i < 60 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("idle wait", busy, 1'b0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input int elat, input string nm);
    int n;
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk({nm, " latency"}, n, elat);
    chk({nm, " q"}, quotient, eq);
    chk({nm, " r"}, remainder, er);
    chk({nm, " dz"}, div_by_zero, edz);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw_done;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset q", quotient, 16'h0000);
    rst = 1'b0;

    run_op(16'd100,   16'd7,     16'd14,    16'd2,    1'b0, 17, "100/7");
    run_op(16'd5,     16'd9,     16'd0,     16'd5,    1'b0, 17, "5/9");
    run_op(16'd65535, 16'd1,     16'd65535, 16'd0,    1'b0, 17, "65535/1");
    run_op(16'd65535, 16'd65535, 16'd1,     16'd0,    1'b0, 17, "65535/65535");
    run_op(16'd1234,  16'd0,     16'hFFFF,  16'd1234, 1'b1, 1,  "1234/0");
`ifdef DIVIDER_SIGNED_EN
    run_op(16'hFFF9,  16'd2,     16'hFFFD,  16'hFFFF, 1'b0, 17, "-7/2");
    run_op(16'd7,     16'hFFFE,  16'hFFFD,  16'd1,    1'b0, 17, "7/-2");
`endif

    // start pulsed mid-run must not disturb the first operation
    wait_idle();
    dividend = 16'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    dividend = 16'd9;
    divisor  = 16'd9;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("midrun latency", n + 5, 17);
    chk("midrun q", quotient, 16'd333);
    chk("midrun r", remainder, 16'd1);

    // reset five edges into a run aborts it
    wait_idle();
    dividend = 16'd500;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort q", quotient, 16'd0);
    chk("abort r", remainder, 16'd0);
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort no done", saw_done, 1'b0);
    run_op(16'd200, 16'd10, 16'd20, 16'd0, 1'b0, 17, "200/10");

    // reset and start on the same edge: reset wins
    wait_idle();
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    rst      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst   = 1'b0;
    chk("rst+start busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("rst+start still idle", busy, 1'b0);

    // randomized traffic, including held start and occasional resets
    for (int i = 0; i < 4000; i++) begin
      start    = ($urandom_range(0, 2) == 0);
      dividend = W'($urandom);
      case ($urandom_range(0, 6))
        0:       divisor = '0;
        1:       divisor = W'($urandom_range(1, 15));
        2:       divisor = dividend;
        3:       divisor = 16'hFFFF;
        4:       divisor = 16'h8000;
        default: divisor = W'($urandom);
      endcase
      rst = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst   = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
    end
    chk("random ops completed", (model_dones >= 100), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
